// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_pkg : shared types and BCD helper for the stopwatch controller
// Rev 1.0
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d == BCD_MAX) ? bcd_t'(0) : d + bcd_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl_if : button inputs and display outputs of stopwatch_ctrl
// Lap button present only when STOPWATCH_LAP_EN is defined.  Rev 1.0
// ============================================================================
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic i_Start_Btn;
    logic i_Clear_Btn;
`ifdef STOPWATCH_LAP_EN
    logic i_Lap_Btn;
`endif
    bcd_t o_Digit_Tens;
    bcd_t o_Digit_Ones;
    logic o_Running;
    logic o_Wrap;

`ifdef STOPWATCH_LAP_EN
    modport slave  (input  i_Start_Btn, i_Clear_Btn, i_Lap_Btn,
                    output o_Digit_Tens, o_Digit_Ones, o_Running, o_Wrap);
    modport master (output i_Start_Btn, i_Clear_Btn, i_Lap_Btn,
                    input  o_Digit_Tens, o_Digit_Ones, o_Running, o_Wrap);
`else
    modport slave  (input  i_Start_Btn, i_Clear_Btn,
                    output o_Digit_Tens, o_Digit_Ones, o_Running, o_Wrap);
    modport master (output i_Start_Btn, i_Clear_Btn,
                    input  o_Digit_Tens, o_Digit_Ones, o_Running, o_Wrap);
`endif

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : 2-FF synchronizer plus hold-time debouncer, press pulse on 0->1
// Rev 1.0
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  wire logic i_Clk,
    input  wire logic i_Rst_n,
    input  wire logic i_Btn,
    output logic      o_Level,
    output logic      o_Press
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;

    // r_cnt counts consecutive cycles the synchronized input disagrees with r_level
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_Btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_Level = r_level;
    assign o_Press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl : IDLE/RUN/PAUSED sequencer, 1 Hz prescaler, 00..99 BCD count
// Optional lap freeze enabled by STOPWATCH_LAP_EN.  Rev 1.0
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  wire logic       i_Clk,
    input  wire logic       i_Rst_n,
    stopwatch_ctrl_if.slave sw
);

    localparam int            PW          = $clog2(TICK_DIV);
    localparam logic [PW-1:0] C_TICK_LAST = PW'(TICK_DIV - 1);

    logic w_start_press, w_start_level;
    logic w_clear_press, w_clear_level;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Btn   (sw.i_Start_Btn),
        .o_Level (w_start_level),
        .o_Press (w_start_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Btn   (sw.i_Clear_Btn),
        .o_Level (w_clear_level),
        .o_Press (w_clear_press)
    );

`ifdef STOPWATCH_LAP_EN
    logic w_lap_press, w_lap_level;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Btn   (sw.i_Lap_Btn),
        .o_Level (w_lap_level),
        .o_Press (w_lap_press)
    );

    logic w_unused_levels;
    assign w_unused_levels = &{1'b0, w_start_level, w_clear_level, w_lap_level};
`else
    logic w_unused_levels;
    assign w_unused_levels = &{1'b0, w_start_level, w_clear_level};
`endif

    sw_state_t     r_state;
    sw_state_t     w_next;
    logic [PW-1:0] r_presc;
    bcd_t          r_tens;
    bcd_t          r_ones;
    logic          r_running;
    logic          r_wrap;
    logic          w_run;
    logic          w_tick;
    logic          w_zero;
    logic          w_at_max;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Clear outranks start in every state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!w_clear_press && w_start_press) w_next = ST_RUN;
            ST_RUN:    if (w_clear_press)      w_next = ST_IDLE;
                       else if (w_start_press) w_next = ST_PAUSED;
            ST_PAUSED: if (w_clear_press)      w_next = ST_IDLE;
                       else if (w_start_press) w_next = ST_RUN;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_run    = (r_state == ST_RUN);
        w_tick   = w_run && (r_presc == C_TICK_LAST);
        w_zero   = (w_next == ST_IDLE);
        w_at_max = (r_tens == BCD_MAX) && (r_ones == BCD_MAX);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_presc   <= '0;
            r_running <= 1'b0;
        end else begin
            r_running <= (w_next == ST_RUN);
            if (w_zero) begin
                r_presc <= '0;
            end else if (w_run) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
        end
    end

    // A clear coinciding with a tick suppresses the increment
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_tens <= '0;
            r_ones <= '0;
            r_wrap <= 1'b0;
        end else if (w_zero) begin
            r_tens <= '0;
            r_ones <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_tick && w_at_max;
            if (w_tick) begin
                r_ones <= bcd_inc(r_ones);
                if (r_ones == BCD_MAX) r_tens <= bcd_inc(r_tens);
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic r_frozen;
    bcd_t r_snap_tens;
    bcd_t r_snap_ones;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_frozen    <= 1'b0;
            r_snap_tens <= '0;
            r_snap_ones <= '0;
        end else if (w_zero) begin
            r_frozen <= 1'b0;
        end else if (w_run && w_lap_press) begin
            r_frozen    <= !r_frozen;
            r_snap_tens <= r_tens;
            r_snap_ones <= r_ones;
        end
    end

    assign sw.o_Digit_Tens = r_frozen ? r_snap_tens : r_tens;
    assign sw.o_Digit_Ones = r_frozen ? r_snap_ones : r_ones;
`else
    assign sw.o_Digit_Tens = r_tens;
    assign sw.o_Digit_Ones = r_ones;
`endif

    assign sw.o_Running = r_running;
    assign sw.o_Wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_ctrl : scoreboard bench for stopwatch_ctrl (TICK_DIV=4, DEBOUNCE_CYCLES=3)
// Rev 1.0
// ============================================================================
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int C_TICK_DIV = 4;
    localparam int C_DEB      = 3;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
        logic       w;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .TICK_DIV        (C_TICK_DIV),
        .DEBOUNCE_CYCLES (C_DEB)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .sw      (sw_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_int  = 1'b0;
    bit   int_first = 1'b1;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic int shown();
        return int'(sw_if.o_Digit_Tens) * 10 + int'(sw_if.o_Digit_Ones);
    endfunction

    task automatic push_exp(input int v, input bit w);
        exp_t e;
        e.t = 4'(v / 10);
        e.o = 4'(v % 10);
        e.w = w;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input int a, input int b);
        for (int v = a; v <= b; v++) push_exp(v, 1'b0);
    endtask

    task automatic press(input bit s, input bit c, input bit l, input int n);
        sw_if.i_Start_Btn = s;
        sw_if.i_Clear_Btn = c;
`ifdef STOPWATCH_LAP_EN
        sw_if.i_Lap_Btn = l;
`else
        if (l) $display("lap stimulus ignored in this build");
`endif
        repeat (n) @(negedge clk);
        sw_if.i_Start_Btn = 1'b0;
        sw_if.i_Clear_Btn = 1'b0;
`ifdef STOPWATCH_LAP_EN
        sw_if.i_Lap_Btn = 1'b0;
`endif
    endtask

    task automatic wait_digits(input int v, input int budget);
        for (int i = 0; i < budget && shown() != v; i++) @(negedge clk);
        chk($sformatf("reach_%0d", v), shown(), v);
    endtask

    task automatic wait_running(input bit v, input int budget);
        for (int i = 0; i < budget && sw_if.o_Running != v; i++) @(negedge clk);
        chk("running_level", int'(sw_if.o_Running), int'(v));
    endtask

    // Scoreboard monitor: every displayed-value change pops one expectation
    int   m_prev;
    int   m_cur;
    int   m_last;
    exp_t m_e;
    initial begin
        m_prev = 0;
        m_last = 0;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge clk);
            m_cur = shown();
            if (m_cur != m_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_change", m_cur, m_prev);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("sb_digits", m_cur, int'(m_e.t) * 10 + int'(m_e.o));
                    chk("sb_wrap", int'(sw_if.o_Wrap), int'(m_e.w));
                end
                if (chk_int) begin
                    if (!int_first) chk("step_interval", cyc - m_last, C_TICK_DIV);
                    int_first = 1'b0;
                end
                m_last = cyc;
                m_prev = m_cur;
            end else begin
                chk("wrap_spurious", int'(sw_if.o_Wrap), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        sw_if.i_Start_Btn = 1'b0;
        sw_if.i_Clear_Btn = 1'b0;
`ifdef STOPWATCH_LAP_EN
        sw_if.i_Lap_Btn = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_digits",  shown(), 0);
        chk("rst_running", int'(sw_if.o_Running), 0);
        chk("rst_wrap",    int'(sw_if.o_Wrap), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Too-short press is rejected, a 5-cycle press starts the count
        press(1'b1, 1'b0, 1'b0, 2);
        repeat (10) @(negedge clk);
        chk("short_press_idle", int'(sw_if.o_Running), 0);

        chk_int   = 1'b1;
        int_first = 1'b1;
        push_seq(1, 10);
        press(1'b1, 1'b0, 1'b0, 5);
        wait_running(1'b1, 10);
        repeat (39) @(negedge clk);
        chk("run_39_cycles", shown(), 9);
        @(negedge clk);
        chk("run_40_cycles", shown(), 10);
        chk("single_press_running", int'(sw_if.o_Running), 1);
        chk_int = 1'b0;

        // Asynchronous reset mid-count
        push_seq(11, 37);
        wait_digits(37, 200);
        push_exp(0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_digits",  shown(), 0);
        chk("async_rst_running", int'(sw_if.o_Running), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Restart from 00 and run through the 99->00 wrap
        push_seq(1, 98);
        press(1'b1, 1'b0, 1'b0, 5);
        wait_running(1'b1, 10);
        chk("restart_from_00", shown(), 0);
        wait_digits(98, 500);
        push_exp(99, 1'b0);
        push_exp(0, 1'b1);
        wait_digits(99, 10);
        wait_digits(0, 10);
        chk("wrap_high", int'(sw_if.o_Wrap), 1);
        @(negedge clk);
        chk("wrap_one_cycle", int'(sw_if.o_Wrap), 0);

        // Pause at 05 with prescaler phase 2, then resume
        push_seq(1, 5);
        wait_digits(4, 30);
        press(1'b1, 1'b0, 1'b0, 5);
        wait_running(1'b0, 10);
        chk("pause_digits", shown(), 5);
        repeat (20) @(negedge clk);
        chk("pause_hold", shown(), 5);
        push_exp(6, 1'b0);
        press(1'b1, 1'b0, 1'b0, 5);
        wait_running(1'b1, 10);
        @(negedge clk);
        chk("resume_phase", shown(), 5);
        @(negedge clk);
        chk("resume_step", shown(), 6);

        // Start and clear together: clear wins
        push_exp(7, 1'b0);
        push_exp(0, 1'b0);
        press(1'b1, 1'b1, 1'b0, 5);
        wait_digits(0, 20);
        wait_running(1'b0, 10);
        repeat (10) @(negedge clk);
        chk("start_clear_idle", int'(sw_if.o_Running), 0);
        chk("start_clear_00", shown(), 0);

`ifdef STOPWATCH_LAP_EN
        // Lap freeze at 12 while the count continues to 17
        push_seq(1, 12);
        press(1'b1, 1'b0, 1'b0, 5);
        wait_digits(11, 80);
        press(1'b0, 1'b0, 1'b1, 5);
        repeat (15) @(negedge clk);
        chk("lap_frozen", shown(), 12);
        push_exp(17, 1'b0);
        push_exp(18, 1'b0);
        press(1'b0, 1'b0, 1'b1, 5);
        wait_digits(17, 10);
        wait_digits(18, 10);
        push_exp(0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 5);
        wait_digits(0, 20);
        wait_running(1'b0, 10);
        push_exp(1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 5);
        wait_digits(1, 20);
        push_exp(0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 5);
        wait_digits(0, 20);
`endif

        repeat (5) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
